// File: rtl/vec_loop_ctrl.sv
//==============================================================================
// vec_loop_ctrl : fill / pass-1 / pass-2 sequencer for the shared vector datapath
// Optional pass 2 built when VEC_LOOP_CTRL_PASS2_EN is defined.  Rev 1.0
//==============================================================================
`default_nettype none

module vec_loop_ctrl #(
  parameter int IDX_W  = 10,
  parameter int LEN_W  = 32,
  parameter int COEF_W = 8,
  parameter int K1     = 2,
  parameter int K2     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  n,
  input  logic              we,
  input  logic              hold,
  output logic              load_a_en,
  output logic              load_b_en,
  output logic              load_c_en,
  output logic              store_ab,
  output logic              store_c_en,
  output logic              mul_en,
  output logic              add_en,
  output logic [1:0]        mul_sel,
  output logic [1:0]        add_sel,
  output logic [COEF_W-1:0] coef,
  output logic [IDX_W-1:0]  index_loop,
  output logic [LEN_W:0]    fill_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_P1_LDB = 4'd2,
    S_P1_LDA = 4'd3,
    S_P1_ADD = 4'd4,
    S_P1_ST  = 4'd5,
    S_DONE   = 4'd6
`ifdef VEC_LOOP_CTRL_PASS2_EN
    ,
    S_P2_LDB = 4'd7,
    S_P2_LDA = 4'd8,
    S_P2_ADD = 4'd9,
    S_P2_MUL = 4'd10,
    S_P2_ST  = 4'd11
`endif
  } state_t;

  localparam logic [LEN_W:0]    DEPTH   = {{LEN_W{1'b0}}, 1'b1} << IDX_W;
  localparam logic [LEN_W:0]    ONE_F   = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  ONE_L   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  ONE_I   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [COEF_W-1:0] COEF_K1 = COEF_W'(K1);
  localparam logic [COEF_W-1:0] COEF_K2 = COEF_W'(K2);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   n_q, n_d;
  logic [LEN_W:0]     fill_cnt_q, fill_cnt_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               err_q, err_d;

  logic               compute;
  logic               fill_last;
  logic               idx_last;
  logic               n_big;

  assign compute   = (state_q != S_IDLE) && (state_q != S_FILL) && (state_q != S_DONE);
  // fill_cnt has one extra bit so 2n never wraps, even for n at full LEN_W range
  assign fill_last = (fill_cnt_q + ONE_F) == {n_q, 1'b0};
  assign idx_last  = ({{(LEN_W-IDX_W){1'b0}}, index_q} + ONE_L) == n_q;
  assign n_big     = {1'b0, n} > DEPTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      fill_cnt_q <= '0;
      index_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      fill_cnt_q <= fill_cnt_d;
      index_q    <= index_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    fill_cnt_d = fill_cnt_q;
    index_d    = index_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d        = n;
          err_d      = 1'b0;
          fill_cnt_d = '0;
          index_d    = '0;
          if (n == '0) begin
            state_d = S_DONE;
          end else if (n_big) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (we) begin
          fill_cnt_d = fill_cnt_q + ONE_F;
          if (fill_last) begin
            index_d = '0;
            state_d = S_P1_LDB;
          end
        end
      end
      S_P1_LDB: state_d = S_P1_LDA;
      S_P1_LDA: state_d = S_P1_ADD;
      S_P1_ADD: state_d = S_P1_ST;
      S_P1_ST: begin
        if (idx_last) begin
          index_d = '0;
`ifdef VEC_LOOP_CTRL_PASS2_EN
          state_d = S_P2_LDB;
`else
          state_d = S_DONE;
`endif
        end else begin
          index_d = index_q + ONE_I;
          state_d = S_P1_LDB;
        end
      end
`ifdef VEC_LOOP_CTRL_PASS2_EN
      S_P2_LDB: state_d = S_P2_LDA;
      S_P2_LDA: state_d = S_P2_ADD;
      S_P2_ADD: state_d = S_P2_MUL;
      S_P2_MUL: state_d = S_P2_ST;
      S_P2_ST: begin
        if (idx_last) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + ONE_I;
          state_d = S_P2_LDB;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // hold freezes only the compute passes; FILL keeps accepting host writes
    if (hold && compute) begin
      state_d = state_q;
      index_d = index_q;
    end
  end

  always_comb begin
    load_a_en  = 1'b0;
    load_b_en  = 1'b0;
    load_c_en  = 1'b0;
    store_ab   = 1'b0;
    store_c_en = 1'b0;
    mul_en     = 1'b0;
    add_en     = 1'b0;
    mul_sel    = 2'b00;
    add_sel    = 2'b00;
    coef       = '0;
    case (state_q)
      S_FILL:   store_ab   = 1'b1;
      S_P1_LDB: load_b_en  = 1'b1;
      S_P1_LDA: begin
        load_a_en = 1'b1;
        mul_en    = 1'b1;
        mul_sel   = 2'b01;
      end
      S_P1_ADD: begin
        add_en  = 1'b1;
        add_sel = 2'b01;
      end
      S_P1_ST:  store_c_en = 1'b1;
`ifdef VEC_LOOP_CTRL_PASS2_EN
      S_P2_LDB: load_b_en  = 1'b1;
      S_P2_LDA: begin
        load_a_en = 1'b1;
        mul_en    = 1'b1;
        mul_sel   = 2'b10;
      end
      S_P2_ADD: begin
        load_c_en = 1'b1;
        add_en    = 1'b1;
        add_sel   = 2'b10;
      end
      S_P2_MUL: begin
        mul_en  = 1'b1;
        mul_sel = 2'b11;
      end
      S_P2_ST:  store_c_en = 1'b1;
`endif
      default: ;
    endcase
    if (hold && compute) begin
      load_a_en  = 1'b0;
      load_b_en  = 1'b0;
      load_c_en  = 1'b0;
      store_c_en = 1'b0;
      mul_en     = 1'b0;
      add_en     = 1'b0;
      mul_sel    = 2'b00;
      add_sel    = 2'b00;
    end
    // the coefficient follows the multiplier select of the a/b multiply steps
    if (mul_sel == 2'b01) begin
      coef = COEF_K1;
    end else if (mul_sel == 2'b10) begin
      coef = COEF_K2;
    end
  end

  assign busy       = compute || (state_q == S_FILL);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign index_loop = index_q;
  assign fill_cnt   = fill_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_loop_ctrl.sv
// Bench for vec_loop_ctrl: datapath model driven by the strobes, expected C writes in a scoreboard queue.
`timescale 1ns/1ps
`default_nettype none

module tb_vec_loop_ctrl;

  localparam int IDX_W = 10, LEN_W = 32, COEF_W = 8, K1 = 2, K2 = 5;
`ifdef VEC_LOOP_CTRL_PASS2_EN
  localparam bit PASS2 = 1'b1;
`else
  localparam bit PASS2 = 1'b0;
`endif
  localparam int CPE = PASS2 ? 9 : 4;

  logic clk, rst, start, we, hold;
  logic [LEN_W-1:0] n_in;
  logic load_a_en, load_b_en, load_c_en, store_ab, store_c_en, mul_en, add_en;
  logic [1:0] mul_sel, add_sel;
  logic [COEF_W-1:0] coef;
  logic [IDX_W-1:0] index_loop;
  logic [LEN_W:0] fill_cnt;
  logic busy, done, err;

  vec_loop_ctrl #(.IDX_W(IDX_W), .LEN_W(LEN_W), .COEF_W(COEF_W), .K1(K1), .K2(K2)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .we(we), .hold(hold),
    .load_a_en(load_a_en), .load_b_en(load_b_en), .load_c_en(load_c_en),
    .store_ab(store_ab), .store_c_en(store_c_en), .mul_en(mul_en), .add_en(add_en),
    .mul_sel(mul_sel), .add_sel(add_sel), .coef(coef), .index_loop(index_loop),
    .fill_cnt(fill_cnt), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int idx; longint val; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int n_cur = 0;
  longint mA[1024], mB[1024], mC[1024];
  longint ra, rb, rprod, rsum, rc, rres;
  int strobe_cyc, fill_cyc, max_fill, max_idx;
  bit bad_sel;

  function automatic bit any_strobe();
    return load_a_en | load_b_en | load_c_en | store_c_en | mul_en | add_en;
  endfunction

  // Host data: A[i] = i+1, B[i] = i+4
  task automatic push_exp(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx = i;
      e.val = longint'(i + 1) + K1 * longint'(i + 4);
      exp_q.push_back(e);
    end
    if (PASS2) begin
      for (int i = 0; i < n; i++) begin
        e.idx = i;
        e.val = (longint'(i + 1) + K1 * longint'(i + 4)) * (longint'(i + 1) + K2 * longint'(i + 4));
        exp_q.push_back(e);
      end
    end
  endtask

  // Datapath model: buffers written via fill_cnt, arithmetic steered by DUT strobes
  always @(negedge clk) begin
    if (!rst) begin
      int idx;
      idx = int'(index_loop);
      if (store_ab && we && fill_cnt < 2 * n_cur && fill_cnt < 2048) begin
        if (fill_cnt < n_cur) mA[int'(fill_cnt)] = longint'(fill_cnt) + 1;
        else                  mB[int'(fill_cnt) - n_cur] = longint'(fill_cnt) - n_cur + 4;
      end
      if (any_strobe()) strobe_cyc++;
      if (store_ab && busy) begin
        fill_cyc++;
        if (int'(fill_cnt) > max_fill) max_fill = int'(fill_cnt);
      end
      if (busy && !store_ab && idx > max_idx) max_idx = idx;
      if (!PASS2 && (load_c_en || mul_sel[1] || add_sel[1])) bad_sel = 1'b1;
      if (load_b_en) rb = mB[idx];
      if (load_a_en) ra = mA[idx];
      if (load_c_en) rc = mC[idx];
      if (mul_en && (mul_sel == 2'b01 || mul_sel == 2'b10)) rprod = longint'(coef) * rb;
      if (add_en && add_sel == 2'b01) rres = ra + rprod;
      if (add_en && add_sel == 2'b10) rsum = ra + rprod;
      if (mul_en && mul_sel == 2'b11) rres = rc * rsum;
      if (store_c_en) begin
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL c_store: unexpected write idx=%0d val=%0d, required none", idx, rres);
        end else begin
          e = exp_q.pop_front();
          if (idx !== e.idx || rres !== e.val) begin
            n_fail++;
            $display("FAIL c_store: got idx=%0d val=%0d, required idx=%0d val=%0d", idx, rres, e.idx, e.val);
          end
        end
        mC[idx] = rres;
      end
    end
  end

  task automatic start_run(input int n);
    n_cur = n; strobe_cyc = 0; fill_cyc = 0; max_fill = 0; max_idx = 0; bad_sel = 1'b0;
    if (n > 0 && n <= 1024) push_exp(n);
    @(posedge clk); #1;
    start = 1'b1; n_in = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives one run from start; lat = edges after the start edge until done (budget+1 on timeout)
  task automatic run_vec(input int n, input bit we_alt, input bit do_hold, input bit busy_start,
                         output int lat, output bit hold_zero_ok, output bit hold_resume_ok);
    int budget, hold_left;
    bit hold_used, trig;
    budget = 13 * n + 20;
    hold_zero_ok = 1'b1; hold_resume_ok = 1'b0; hold_left = 0; hold_used = 1'b0;
    we = !we_alt;
    start_run(n);
    lat = budget + 1;
    if (done) lat = 0;
    for (int cyc = 1; cyc <= budget && lat > budget; cyc++) begin
      we = we_alt ? ((cyc % 2) == 0) : 1'b1;
      if (busy_start) begin
        start = (cyc == 3);
        n_in = LEN_W'(5);
      end
      @(posedge clk); #1;
      if (done) begin
        lat = cyc;
      end else begin
        trig = PASS2 ? load_c_en : add_en;
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) begin
            hold = 1'b0; #1;
            hold_resume_ok = PASS2 ? load_c_en : add_en;
          end else begin
            #1;
            if (any_strobe()) hold_zero_ok = 1'b0;
          end
        end else if (do_hold && !hold_used && trig) begin
          hold = 1'b1; hold_used = 1'b1; hold_left = 3; #1;
          if (any_strobe()) hold_zero_ok = 1'b0;
        end
      end
    end
    we = 1'b0; hold = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({load_a_en, load_b_en, load_c_en, store_ab, store_c_en, mul_en, add_en} !== 7'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b, required 0", {load_a_en, load_b_en, load_c_en, store_ab, store_c_en, mul_en, add_en});
    end
    n_checks++;
    if ({mul_sel, add_sel} !== 4'b0) begin n_fail++; $display("FAIL reset_sel: got %b, required 0", {mul_sel, add_sel}); end
    n_checks++;
    if (coef !== '0) begin n_fail++; $display("FAIL reset_coef: got %0d, required 0", coef); end
    n_checks++;
    if (index_loop !== '0) begin n_fail++; $display("FAIL reset_index: got %0d, required 0", index_loop); end
    n_checks++;
    if (fill_cnt !== '0) begin n_fail++; $display("FAIL reset_fill_cnt: got %0d, required 0", fill_cnt); end
    n_checks++;
    if ({busy, done, err} !== 3'b0) begin n_fail++; $display("FAIL reset_status: got %b, required 000", {busy, done, err}); end
    rst = 1'b0;
  endtask

  task automatic test_full();
    int lat; bit hz, hr;
    run_vec(3, 1'b0, 1'b0, 1'b0, lat, hz, hr);
    n_checks++;
    if (lat !== 2 * 3 + CPE * 3) begin n_fail++; $display("FAIL full_latency: got %0d, required %0d", lat, 2 * 3 + CPE * 3); end
    n_checks++;
    if (strobe_cyc !== CPE * 3) begin n_fail++; $display("FAIL full_strobe_cycles: got %0d, required %0d", strobe_cyc, CPE * 3); end
    n_checks++;
    if (fill_cyc !== 6) begin n_fail++; $display("FAIL full_fill_cycles: got %0d, required 6", fill_cyc); end
    n_checks++;
    if (bad_sel !== 1'b0) begin n_fail++; $display("FAIL full_pass2_signals: got 1, required 0"); end
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_status: got err=%b busy=%b, required 0 0", err, busy); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL full_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_hold();
    int lat; bit hz, hr;
    run_vec(2, 1'b0, 1'b1, 1'b0, lat, hz, hr);
    n_checks++;
    if (lat !== 4 + CPE * 2 + 3) begin n_fail++; $display("FAIL hold_latency: got %0d, required %0d", lat, 4 + CPE * 2 + 3); end
    n_checks++;
    if (hz !== 1'b1) begin n_fail++; $display("FAIL hold_strobes_off: got strobe during hold, required none"); end
    n_checks++;
    if (hr !== 1'b1) begin n_fail++; $display("FAIL hold_resume: got 0, required held-state strobe 1"); end
    n_checks++;
    if (strobe_cyc !== CPE * 2) begin n_fail++; $display("FAIL hold_strobe_cycles: got %0d, required %0d", strobe_cyc, CPE * 2); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL hold_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_edge_lengths();
    int lat; bit hz, hr;
    run_vec(0, 1'b0, 1'b0, 1'b0, lat, hz, hr);
    n_checks++;
    if (lat !== 0 || err !== 1'b0 || strobe_cyc !== 0) begin
      n_fail++; $display("FAIL n0: got lat=%0d err=%b strobes=%0d, required 0 0 0", lat, err, strobe_cyc);
    end
    run_vec(1025, 1'b0, 1'b0, 1'b0, lat, hz, hr);
    n_checks++;
    if (lat !== 0 || err !== 1'b1) begin n_fail++; $display("FAIL n_too_big: got lat=%0d err=%b, required 0 1", lat, err); end
    n_checks++;
    if (strobe_cyc !== 0 || fill_cyc !== 0) begin n_fail++; $display("FAIL n_too_big_strobes: got %0d/%0d, required 0/0", strobe_cyc, fill_cyc); end
    run_vec(1024, 1'b0, 1'b0, 1'b0, lat, hz, hr);
    n_checks++;
    if (lat !== 2048 + CPE * 1024) begin n_fail++; $display("FAIL n_max_latency: got %0d, required %0d", lat, 2048 + CPE * 1024); end
    n_checks++;
    if (max_idx !== 1023 || err !== 1'b0) begin n_fail++; $display("FAIL n_max_index: got idx=%0d err=%b, required 1023 0", max_idx, err); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL n_max_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midrun();
    int lat; bit hz, hr, found;
    found = 1'b0;
    we = 1'b1;
    start_run(2);
    for (int cyc = 0; cyc < 60 && !found; cyc++) begin
      @(posedge clk); #1;
      if (add_en && add_sel == 2'b01 && index_loop == 1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midrun_reach_p1_add: got not reached, required reached"); end
    rst = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({load_a_en, load_b_en, load_c_en, store_ab, store_c_en, mul_en, add_en, mul_sel, add_sel} !== 11'b0 ||
        coef !== '0 || index_loop !== '0 || fill_cnt !== '0 || {busy, done, err} !== 3'b0) begin
      n_fail++; $display("FAIL midrun_reset_outputs: got busy=%b done=%b idx=%0d fill=%0d, required all 0", busy, done, index_loop, fill_cnt);
    end
    rst = 1'b0;
    exp_q.delete();
    run_vec(1, 1'b0, 1'b0, 1'b0, lat, hz, hr);
    n_checks++;
    if (lat !== 2 + CPE) begin n_fail++; $display("FAIL midrun_restart_latency: got %0d, required %0d", lat, 2 + CPE); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL midrun_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_busy_start();
    int lat; bit hz, hr;
    run_vec(2, 1'b0, 1'b0, 1'b1, lat, hz, hr);
    n_checks++;
    if (lat !== 4 + CPE * 2) begin n_fail++; $display("FAIL busy_start_latency: got %0d, required %0d", lat, 4 + CPE * 2); end
    n_checks++;
    if (strobe_cyc !== CPE * 2) begin n_fail++; $display("FAIL busy_start_strobes: got %0d, required %0d", strobe_cyc, CPE * 2); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL busy_start_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_fill_gap();
    int lat; bit hz, hr;
    run_vec(2, 1'b1, 1'b0, 1'b0, lat, hz, hr);
    n_checks++;
    if (fill_cyc !== 8) begin n_fail++; $display("FAIL gap_fill_cycles: got %0d, required 8", fill_cyc); end
    n_checks++;
    if (max_fill !== 3) begin n_fail++; $display("FAIL gap_fill_cnt_max: got %0d, required 3", max_fill); end
    n_checks++;
    if (lat !== 8 + CPE * 2) begin n_fail++; $display("FAIL gap_latency: got %0d, required %0d", lat, 8 + CPE * 2); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL gap_pending: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; hold = 1'b0; n_in = '0;
    test_reset();
    test_full();
    test_hold();
    test_edge_lengths();
    test_reset_midrun();
    test_busy_start();
    test_fill_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got no completion, required finish before 3ms");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
